// File: rtl/mac_seq_pkg.sv
// mac_seq_pkg: shared state type, width derivation and saturation bounds for the MAC sequencer
package mac_seq_pkg;
  typedef enum logic [1:0] {IDLE, ACC, DRAIN} state_t;
  function automatic int psum_width(input int dw);
    return dw * 2 + 6;
  endfunction
  function automatic int sat_max(input int dw);
    return 2 ** (dw - 1) - 1;
  endfunction
  function automatic int sat_min(input int dw);
    return -(2 ** (dw - 1));
  endfunction
  localparam int DATA_W  = 8;
  localparam int PSUM_W  = psum_width(DATA_W);
  localparam int SAT_MAX = sat_max(DATA_W);
  localparam int SAT_MIN = sat_min(DATA_W);
endpackage

// File: rtl/requant_sat.sv
// requant_sat: arithmetic right shift with half-up rounding, saturated to DATA_WIDTH
module requant_sat
  import mac_seq_pkg::*;
#(
  parameter int DATA_WIDTH = 8,
  parameter int PSUM_WIDTH = psum_width(DATA_WIDTH)
) (
  input  logic signed [PSUM_WIDTH-1:0] sum,
  input  logic        [3:0]            shift,
  output logic signed [DATA_WIDTH-1:0] q
);
  localparam int W = PSUM_WIDTH + 1;
  localparam logic signed [W-1:0] HI = W'(sat_max(DATA_WIDTH));
  localparam logic signed [W-1:0] LO = W'(sat_min(DATA_WIDTH));
  logic signed [W-1:0] ext, rnd, shr;
  // one extra bit of headroom keeps the rounding add from wrapping
  always_comb begin
    ext = {sum[PSUM_WIDTH-1], sum};
    rnd = (shift == 4'd0) ? '0 : W'(1) << (shift - 4'd1);
    shr = (ext + rnd) >>> shift;
    q   = (shr > HI) ? HI[DATA_WIDTH-1:0] : (shr < LO) ? LO[DATA_WIDTH-1:0] : shr[DATA_WIDTH-1:0];
  end
endmodule

// File: rtl/mac_cluster_seq.sv
// mac_cluster_seq: chunked accumulation sequencer for one MAC cluster with partial-sum buffer
// and requantized valid/ready result drain
module mac_cluster_seq
  import mac_seq_pkg::*;
#(
  parameter int DATA_WIDTH  = 8,
  parameter int PSUM_WIDTH  = psum_width(DATA_WIDTH),
  parameter int POS_WIDTH   = 5,
  parameter int CHUNK_WIDTH = 8
) (
  input  logic                          clk,
  input  logic                          rst_n,
  input  logic                          cfg_start,
  input  logic        [POS_WIDTH-1:0]   cfg_num_pos,
  input  logic        [CHUNK_WIDTH-1:0] cfg_num_chunk,
  input  logic                          cfg_relu,
  input  logic        [3:0]             cfg_shift,
  output logic                          busy,
  output logic                          done,
  input  logic                          op_valid,
  output logic                          op_ready,
  output logic        [CHUNK_WIDTH-1:0] cur_chunk,
  output logic        [POS_WIDTH-1:0]   cur_pos,
  output logic                          mac_en,
  output logic                          mac_add_bias,
  output logic                          mac_relu,
  output logic                          mac_done,
  output logic        [PSUM_WIDTH-1:0]  mac_psum,
  input  logic signed [PSUM_WIDTH-1:0]  mac_total_sum,
  output logic                          res_valid,
  input  logic                          res_ready,
  output logic signed [DATA_WIDTH-1:0]  res_data,
  output logic        [POS_WIDTH-1:0]   res_pos
);
  state_t state;
  logic [POS_WIDTH-1:0] num_pos;
  logic [CHUNK_WIDTH-1:0] num_chunk;
  logic relu_q;
  logic [3:0] shift_q;
  logic [PSUM_WIDTH-1:0] psum_buf [2**POS_WIDTH];
  logic acc, last_chunk, last_pos, fire, res_hs;
  logic signed [PSUM_WIDTH-1:0] rq_in;
  logic signed [DATA_WIDTH-1:0] rq_out;
  assign acc          = state == ACC;
  assign last_chunk   = cur_chunk == num_chunk;
  assign last_pos     = cur_pos == num_pos;
  assign res_hs       = res_valid && res_ready;
  // the final chunk may only fire when the result slot is free or draining this cycle
  assign op_ready     = acc && (!last_chunk || !res_valid || res_ready);
  assign fire         = op_valid && op_ready;
  assign mac_en       = fire;
  assign mac_add_bias = acc && cur_chunk == '0;
  assign mac_done     = acc && last_chunk;
  assign mac_relu     = mac_done && relu_q;
  assign mac_psum     = (acc && cur_chunk != '0) ? psum_buf[cur_pos] : '0;
  assign busy         = state != IDLE;
  assign done         = state == DRAIN && res_hs;
  assign rq_in        = (mac_relu && mac_total_sum[PSUM_WIDTH-1]) ? '0 : mac_total_sum;
  requant_sat #(.DATA_WIDTH(DATA_WIDTH), .PSUM_WIDTH(PSUM_WIDTH)) u_rq (
    .sum  (rq_in),
    .shift(shift_q),
    .q    (rq_out)
  );
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state     <= IDLE;
      cur_chunk <= '0;
      cur_pos   <= '0;
      num_pos   <= '0;
      num_chunk <= '0;
      relu_q    <= 1'b0;
      shift_q   <= '0;
      res_valid <= 1'b0;
      res_data  <= '0;
      res_pos   <= '0;
    end else begin
      if (fire && last_chunk) begin
        res_valid <= 1'b1;
        res_data  <= rq_out;
        res_pos   <= cur_pos;
      end else if (res_hs) begin
        res_valid <= 1'b0;
      end
      case (state)
        IDLE: if (cfg_start) begin
          state     <= ACC;
          num_pos   <= cfg_num_pos;
          num_chunk <= cfg_num_chunk;
          relu_q    <= cfg_relu;
          shift_q   <= cfg_shift;
          cur_chunk <= '0;
          cur_pos   <= '0;
        end
        ACC: if (fire) begin
          cur_pos <= last_pos ? '0 : cur_pos + 1'b1;
          if (last_pos) begin
            cur_chunk <= last_chunk ? '0 : cur_chunk + 1'b1;
            if (last_chunk) state <= DRAIN;
          end
        end
        DRAIN: if (res_hs) state <= IDLE;
        default: state <= IDLE;
      endcase
    end
  end
  always_ff @(posedge clk) if (fire && !last_chunk) psum_buf[cur_pos] <= mac_total_sum;
endmodule

// File: tb/tb_mac_cluster_seq.sv
// tb_mac_cluster_seq: scoreboard bench with a behavioural cluster model driving mac_total_sum
module tb_mac_cluster_seq;
  localparam int DW = 8, PW = 22, PS = 5, CW = 8;
  logic clk = 1'b0, rst_n = 1'b0;
  logic cfg_start = 1'b0, cfg_relu = 1'b0;
  logic [PS-1:0] cfg_num_pos = '0;
  logic [CW-1:0] cfg_num_chunk = '0;
  logic [3:0] cfg_shift = '0;
  logic busy, done, op_ready, mac_en, mac_add_bias, mac_relu, mac_done, res_valid;
  logic op_valid = 1'b0, res_ready = 1'b0;
  logic [CW-1:0] cur_chunk;
  logic [PS-1:0] cur_pos, res_pos;
  logic [PW-1:0] mac_psum, mac_total_sum;
  logic [DW-1:0] res_data;
  int errors = 0, checks = 0;
  int mode = 0, step = 10;
  int tbl [32];
  int mb [32];
  int exp_d [$];
  int exp_p [$];
  mac_cluster_seq dut (
    .clk(clk), .rst_n(rst_n), .cfg_start(cfg_start), .cfg_num_pos(cfg_num_pos),
    .cfg_num_chunk(cfg_num_chunk), .cfg_relu(cfg_relu), .cfg_shift(cfg_shift),
    .busy(busy), .done(done), .op_valid(op_valid), .op_ready(op_ready),
    .cur_chunk(cur_chunk), .cur_pos(cur_pos), .mac_en(mac_en), .mac_add_bias(mac_add_bias),
    .mac_relu(mac_relu), .mac_done(mac_done), .mac_psum(mac_psum), .mac_total_sum(mac_total_sum),
    .res_valid(res_valid), .res_ready(res_ready), .res_data(res_data), .res_pos(res_pos)
  );
  always #5 clk = ~clk;
  // cluster model: either accumulate a fixed step onto psum or return a per-position table value
  always_comb mac_total_sum = (mode == 0) ? mac_psum + PW'(step) : PW'(tbl[cur_pos]);
  function automatic int ref_q(input int s, input int sh, input bit rl);
    int v;
    v = (rl && s < 0) ? 0 : s;
    if (sh > 0) v = (v + (1 << (sh - 1))) >>> sh;
    return (v > 127) ? 127 : (v < -128) ? -128 : v;
  endfunction
  task automatic run_job(input string tag, input int np, input int nc, input bit rl, input int sh,
                         input bit ov_rand, input int hold_from, input int hold_len,
                         input int abort_at, input bit poke);
    int ch, p, cyc, ms, ed, epos, ev;
    bit acc, pend, fin, fire, hs, erdy;
    @(negedge clk);
    cfg_num_pos = PS'(np);
    cfg_num_chunk = CW'(nc);
    cfg_relu = rl;
    cfg_shift = 4'(sh);
    cfg_start = 1'b1;
    @(negedge clk);
    cfg_start = poke;
    ch = 0; p = 0; acc = 1; pend = 0; fin = 0; cyc = 0;
    exp_d.delete();
    exp_p.delete();
    while (!fin && cyc != abort_at && cyc < 3000) begin
      op_valid = ov_rand ? ($urandom_range(0, 3) != 0) : 1'b1;
      res_ready = !(cyc >= hold_from && cyc < hold_from + hold_len);
      #1;
      erdy = acc && (ch != nc || !pend || res_ready);
      fire = op_valid && erdy;
      hs = pend && res_ready;
      ev = (ch == 0) ? 0 : mb[p];
      checks++;
      if ({busy, op_ready, mac_en, res_valid, done} !== {1'b1, erdy, fire, pend, hs && !acc}) begin
        errors++;
        $display("FAIL %s ctrl cyc=%0d: busy/rdy/en/rv/done got %b want %b", tag, cyc,
                 {busy, op_ready, mac_en, res_valid, done}, {1'b1, erdy, fire, pend, hs && !acc});
      end
      checks++;
      if (acc && {cur_chunk, cur_pos, mac_add_bias, mac_done, mac_relu, mac_psum} !==
                 {CW'(ch), PS'(p), ch == 0, ch == nc, rl && ch == nc, PW'(ev)}) begin
        errors++;
        $display("FAIL %s mac cyc=%0d: chunk/pos/bias/done/relu/psum got %h want %h", tag, cyc,
                 {cur_chunk, cur_pos, mac_add_bias, mac_done, mac_relu, mac_psum},
                 {CW'(ch), PS'(p), ch == 0, ch == nc, rl && ch == nc, PW'(ev)});
      end else if (!acc && {mac_add_bias, mac_done, mac_relu, mac_psum} !== '0) begin
        errors++;
        $display("FAIL %s mac_drain cyc=%0d: got %h want 0", tag, cyc,
                 {mac_add_bias, mac_done, mac_relu, mac_psum});
      end
      if (hs) begin
        checks++;
        if (exp_d.size() == 0) begin
          errors++;
          $display("FAIL %s result cyc=%0d: got pos %0d with nothing expected", tag, cyc, res_pos);
        end else begin
          ed = exp_d.pop_front();
          epos = exp_p.pop_front();
          if ({res_data, res_pos} !== {DW'(ed), PS'(epos)}) begin
            errors++;
            $display("FAIL %s result cyc=%0d: data/pos got %0d/%0d want %0d/%0d", tag, cyc,
                     $signed(res_data), res_pos, ed, epos);
          end
        end
        if (!acc) fin = 1;
      end
      if (fire) begin
        ms = (mode == 0) ? ev + step : tbl[p];
        if (ch == nc) begin
          exp_d.push_back(ref_q(ms, sh, rl));
          exp_p.push_back(p);
        end else begin
          mb[p] = ms;
        end
      end
      pend = (fire && ch == nc) ? 1'b1 : hs ? 1'b0 : pend;
      if (fire) begin
        if (p == np) begin
          p = 0;
          if (ch == nc) begin
            ch = 0;
            acc = 0;
          end else ch++;
        end else p++;
      end
      @(negedge clk);
      cyc++;
    end
    cfg_start = 1'b0;
    if (cyc == abort_at) return;
    op_valid = 1'b0;
    res_ready = 1'b0;
    checks++;
    if (cyc >= 3000) begin
      errors++;
      $display("FAIL %s timeout: job did not complete within 3000 cycles", tag);
    end
    #1;
    checks++;
    if ({busy, done, res_valid, op_ready} !== 4'b0 || exp_d.size() != 0) begin
      errors++;
      $display("FAIL %s end: busy/done/rv/rdy got %b want 0000, %0d results left",
               tag, {busy, done, res_valid, op_ready}, exp_d.size());
    end
  endtask
  task automatic test_reset;
    rst_n = 1'b0;
    op_valid = 1'b1;
    res_ready = 1'b1;
    repeat (3) @(negedge clk);
    #1;
    checks++;
    if ({busy, done, op_ready, res_valid, res_data, res_pos, cur_chunk, cur_pos, mac_en,
         mac_add_bias, mac_relu, mac_done, mac_psum} !== '0) begin
      errors++;
      $display("FAIL reset_values: got %h want 0", {busy, done, op_ready, res_valid, res_data,
               res_pos, cur_chunk, cur_pos, mac_en, mac_add_bias, mac_relu, mac_done, mac_psum});
    end
    @(negedge clk);
    rst_n = 1'b1;
    op_valid = 1'b0;
    res_ready = 1'b0;
  endtask
  task automatic test_single;
    mode = 1;
    tbl[0] = 37;
    run_job("single", 0, 0, 1'b0, 0, 1'b0, 0, 0, -1, 1'b1);
  endtask
  task automatic test_multi_chunk;
    mode = 0;
    step = 10;
    run_job("multi", 3, 2, 1'b0, 0, 1'b1, 0, 0, -1, 1'b0);
  endtask
  task automatic test_saturation;
    mode = 1;
    tbl[0] = 2000;
    tbl[1] = 2040;
    tbl[2] = -3000;
    tbl[3] = 24;
    run_job("sat", 3, 0, 1'b0, 4, 1'b1, 0, 0, -1, 1'b0);
  endtask
  task automatic test_relu;
    mode = 1;
    tbl[0] = -50;
    tbl[1] = -50;
    run_job("relu", 1, 1, 1'b1, 0, 1'b0, 0, 0, -1, 1'b0);
  endtask
  task automatic test_back_to_back;
    mode = 0;
    step = 7;
    run_job("backpressure", 3, 1, 1'b0, 1, 1'b0, 4, 5, -1, 1'b0);
  endtask
  task automatic test_reset_mid;
    mode = 1;
    for (int i = 0; i < 8; i++) tbl[i] = 40 * i + 13;
    run_job("pre_reset", 7, 1, 1'b0, 0, 1'b0, 0, 100, 10, 1'b0);
    rst_n = 1'b0;
    #1;
    checks++;
    if ({busy, done, op_ready, res_valid, res_data, res_pos, cur_chunk, cur_pos, mac_en,
         mac_add_bias, mac_relu, mac_done, mac_psum} !== '0) begin
      errors++;
      $display("FAIL reset_mid: got %h want 0", {busy, done, op_ready, res_valid, res_data,
               res_pos, cur_chunk, cur_pos, mac_en, mac_add_bias, mac_relu, mac_done, mac_psum});
    end
    @(negedge clk);
    rst_n = 1'b1;
    op_valid = 1'b0;
    res_ready = 1'b0;
    mode = 0;
    step = 10;
    run_job("post_reset", 5, 1, 1'b0, 0, 1'b1, 0, 0, -1, 1'b0);
  endtask
  initial begin
    test_reset;
    test_single;
    test_multi_chunk;
    test_saturation;
    test_relu;
    test_back_to_back;
    test_reset_mid;
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end
endmodule

// File: doc/mac_cluster_seq.md
# mac_cluster_seq

Sequencer and result drain for one MAC cluster. Drives the cluster's operand-side controls (`en`, `add_bias`, `relu`, `done`, `psum`) over a chunked accumulation, holds per-position partial sums in its own buffer, and requantizes each final sum to DATA_WIDTH. Final results go out through a valid/ready port. It sits between the layer controller/operand fetch and the output activation buffer. The cluster's local-cache ports are not used: integration ties `in_cache_wr_en` low and `in_cache_clear` high.

## Interface
- DATA_WIDTH, 8, operand/result width
- PSUM_WIDTH, DATA_WIDTH*2+6, cluster sum width (22)
- POS_WIDTH, 5, output-position index width (32 positions)
- CHUNK_WIDTH, 8, input-chunk counter width

- clk  in  1  clock
- rst_n  in  1  reset, asynchronous, active-low
- cfg_start  in  1  start pulse; latches cfg_* when idle, ignored when busy
- cfg_num_pos  in  POS_WIDTH  positions minus 1
- cfg_num_chunk  in  CHUNK_WIDTH  input chunks minus 1
- cfg_relu  in  1  apply ReLU on final chunk
- cfg_shift  in  4  requantization right shift (0..15)
- busy  out  1  job in progress
- done  out  1  one-cycle pulse when the job's last result is accepted
- op_valid  in  1  operands for current (chunk,pos) present on cluster data/weight bus
- op_ready  out  1  sequencer accepts operands this cycle
- cur_chunk  out  CHUNK_WIDTH  chunk index for operand fetch
- cur_pos  out  POS_WIDTH  position index for operand fetch
- mac_en  out  1  to cluster `in_en`; equals op_valid && op_ready
- mac_add_bias  out  1  to cluster `in_add_bias`
- mac_relu  out  1  to cluster `in_relu`
- mac_done  out  1  to cluster `in_done`
- mac_psum  out  PSUM_WIDTH  to cluster `in_psum`
- mac_total_sum  in  PSUM_WIDTH  from cluster `out_total_sum` (combinational, same cycle)
- res_valid  out  1  result valid
- res_ready  in  1  downstream accepts result
- res_data  out  DATA_WIDTH  signed requantized result
- res_pos  out  POS_WIDTH  position of res_data

## Operation
- States: IDLE, ACC, DRAIN. IDLE→ACC on cfg_start; ACC→DRAIN on handshake of (last chunk, last pos); DRAIN→IDLE when the final result is accepted, with `done` pulsing in the same cycle.
- Loop order: chunk outer, pos inner. A fire is op_valid && op_ready. Each fire advances pos; pos wrap advances chunk.
- Per fire:
  - mac_add_bias = (chunk==0)
  - mac_psum = 0 when chunk==0, otherwise buf[pos]
  - mac_done = (chunk==last)
  - mac_relu = cfg_relu && (chunk==last)
- Non-final chunk fire: buf[pos] ← mac_total_sum.
- Final chunk fire: the result register loads requant(mac_total_sum) and res_pos ← pos; res_valid is set.
- Requant:
  - Arithmetic shift right by cfg_shift, rounding half-up (add 1<<(shift-1) when shift>0).
  - Saturate to [-2^(DATA_WIDTH-1), 2^(DATA_WIDTH-1)-1].
  - Computed at PSUM_WIDTH+1 bits so the rounding add cannot overflow.
- op_ready = ACC && (chunk!=last || !res_valid || res_ready). The result slot may drain and refill in the same cycle.
- Single chunk (cfg_num_chunk=0): bias, ReLU and result emission all happen on the same fire. With cfg_num_pos=0, the job is exactly one fire.
- buf is not reset; chunk 0 never reads it.

## Timing
- Reset values: busy=0, done=0, op_ready=0, res_valid=0, res_data=0, res_pos=0, cur_chunk=0, cur_pos=0. All mac_* outputs are 0.
- cfg_start at cycle t: busy=1 and op_ready may be 1 from t+1.
- mac_* outputs are combinational from state and counters. mac_en is combinational from op_valid, a single-cycle path through the cluster.
- Result latency: res_valid rises the cycle after the final-chunk fire. It is held, with res_data stable, until res_ready.
- done is high in the cycle the last result handshakes. busy falls the next cycle.
- cfg_start in the same cycle as done is ignored; a new job starts only from IDLE.
- rst_n asserted mid-job: immediate return to IDLE. Any pending result is dropped.

## Structure
- Shared package `mac_seq_pkg`:
  - state enum (IDLE/ACC/DRAIN)
  - PSUM_WIDTH derivation
  - saturation bounds constants
- Sub-module `requant_sat`: combinational shift, round and saturate (PSUM_WIDTH→DATA_WIDTH). Reusable by other clusters.
- buf: 2^POS_WIDTH × PSUM_WIDTH register array inside the sequencer, one write port and one read port.

## Test plan
- Single chunk, one position (num_chunk=0, num_pos=0, shift=0, relu=0), mac_total_sum=37. Expect: mac_add_bias=1, mac_psum=0, mac_done=1, then res_data=37, res_pos=0, and done in the acceptance cycle.
- Three chunks, four positions, cluster model returning psum+10 per fire. Expect: chunk 1/2 mac_psum equals the prior buf value; final res_data=30 for every position, emitted in order 0..3.
- Saturation/rounding with shift=4:
  - sum 2000 → 125
  - sum 2040 → 127 (saturated)
  - sum -3000 → -128
  - sum 24 → 2 (rounds up)
- ReLU: relu=1, two chunks, final sum -50. Expect mac_relu=1 only on chunk 1 and res_data=0.
- Backpressure: hold res_ready=0 for 5 cycles during the final chunk. Expect op_ready=0 after one result is pending, then same-cycle drain/refill once res_ready=1. No result lost or duplicated.
- Reset mid-ACC, then a new job. Expect all outputs at reset values, and the new job's results match the reference with no stale-buf effect.
